// File: rtl/pixart_blob_decoder.sv
// rtl/pixart_blob_decoder.sv - unpacks PixArt IR camera extended-mode read bursts into per-blob X/Y/size/present
module pixart_blob_decoder #(
    parameter int HEADER_BYTES = 1,
    parameter int NUM_BLOBS    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   frame_start_i,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_data_i,
    input  logic                   frame_end_i,
    output logic [10*NUM_BLOBS-1:0] blob_x_o,
    output logic [10*NUM_BLOBS-1:0] blob_y_o,
    output logic [4*NUM_BLOBS-1:0]  blob_size_o,
    output logic [NUM_BLOBS-1:0]    blob_present_o,
    output logic                   frame_valid_o,
    output logic                   frame_error_o,
    output logic [7:0]             frame_count_o
);

    localparam int HW = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
    localparam int BW = (NUM_BLOBS > 1) ? $clog2(NUM_BLOBS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    // With no header the burst goes straight to blob data.
    localparam state_t START_STATE = (HEADER_BYTES == 0) ? S_DATA : S_HDR;

    state_t state_q, state_d;
    logic [HW-1:0] hdr_q, hdr_d;
    logic [1:0]    k_q, k_d;
    logic [BW-1:0] blob_q, blob_d;

    logic [10*NUM_BLOBS-1:0] xsh_q, xsh_d, ysh_q, ysh_d;
    logic [4*NUM_BLOBS-1:0]  ssh_q, ssh_d;
    logic [NUM_BLOBS-1:0]    psh_q, psh_d;

    logic [10*NUM_BLOBS-1:0] x_q, x_d, y_q, y_d;
    logic [4*NUM_BLOBS-1:0]  s_q, s_d;
    logic [NUM_BLOBS-1:0]    p_q, p_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_error_q, frame_error_d;
    logic [7:0]              frame_count_q, frame_count_d;

    // Position the incoming byte is decoded at, after any restart/abort this cycle.
    state_t        eff_state;
    logic [HW-1:0] eff_hdr;
    logic [1:0]    eff_k;
    logic [BW-1:0] eff_blob;
    logic          commit;

    // State register and all shadow/visible registers; cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            hdr_q         <= '0;
            k_q           <= '0;
            blob_q        <= '0;
            xsh_q         <= '0;
            ysh_q         <= '0;
            ssh_q         <= '0;
            psh_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            s_q           <= '0;
            p_q           <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            k_q           <= k_d;
            blob_q        <= blob_d;
            xsh_q         <= xsh_d;
            ysh_q         <= ysh_d;
            ssh_q         <= ssh_d;
            psh_q         <= psh_d;
            x_q           <= x_d;
            y_q           <= y_d;
            s_q           <= s_d;
            p_q           <= p_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next state: commit wins over restart/abort, then the byte is decoded at the effective position.
    always_comb begin
        xsh_d         = xsh_q;
        ysh_d         = ysh_q;
        ssh_d         = ssh_q;
        psh_d         = psh_q;
        x_d           = x_q;
        y_d           = y_q;
        s_d           = s_q;
        p_d           = p_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
        frame_count_d = frame_count_q;
        eff_state     = state_q;
        eff_hdr       = hdr_q;
        eff_k         = k_q;
        eff_blob      = blob_q;

        commit = (state_q == S_DATA) && byte_valid_i && (k_q == 2'd2)
                 && (int'(blob_q) == NUM_BLOBS - 1);

        if (!commit) begin
            if (frame_start_i) begin
                frame_error_d = (state_q != S_IDLE);
                eff_state     = START_STATE;
                eff_hdr       = '0;
                eff_k         = '0;
                eff_blob      = '0;
            end else if (frame_end_i && (state_q != S_IDLE)) begin
                frame_error_d = 1'b1;
                eff_state     = S_IDLE;
                eff_hdr       = '0;
                eff_k         = '0;
                eff_blob      = '0;
            end
        end

        state_d = eff_state;
        hdr_d   = eff_hdr;
        k_d     = eff_k;
        blob_d  = eff_blob;

        if (byte_valid_i && (eff_state == S_HDR)) begin
            if (int'(eff_hdr) == HEADER_BYTES - 1) begin
                state_d = S_DATA;
                hdr_d   = '0;
            end else begin
                hdr_d = eff_hdr + 1'b1;
            end
        end else if (byte_valid_i && (eff_state == S_DATA)) begin
            for (int i = 0; i < NUM_BLOBS; i++) begin
                if (int'(eff_blob) == i) begin
                    case (eff_k)
                        2'd0: xsh_d[10*i +: 8] = byte_data_i;
                        2'd1: ysh_d[10*i +: 8] = byte_data_i;
                        default: begin
                            ysh_d[10*i+8 +: 2] = byte_data_i[7:6];
                            xsh_d[10*i+8 +: 2] = byte_data_i[5:4];
                            ssh_d[4*i +: 4]    = byte_data_i[3:0];
                            psh_d[i]           = !((xsh_q[10*i +: 8] == 8'hFF)
                                                   && (ysh_q[10*i +: 8] == 8'hFF)
                                                   && (byte_data_i == 8'hFF));
                        end
                    endcase
                end
            end
            if (eff_k == 2'd2) begin
                k_d    = 2'd0;
                blob_d = eff_blob + 1'b1;
            end else begin
                k_d = eff_k + 2'd1;
            end
        end

        if (commit) begin
            x_d           = xsh_d;
            y_d           = ysh_d;
            s_d           = ssh_d;
            p_d           = psh_d;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
            state_d       = frame_start_i ? START_STATE : S_IDLE;
            hdr_d         = '0;
            k_d           = '0;
            blob_d        = '0;
        end
    end

    assign blob_x_o       = x_q;
    assign blob_y_o       = y_q;
    assign blob_size_o    = s_q;
    assign blob_present_o = p_q;
    assign frame_valid_o  = frame_valid_q;
    assign frame_error_o  = frame_error_q;
    assign frame_count_o  = frame_count_q;

endmodule
